// File: rtl/spw_pio_tx_bridge.sv
// PIO-to-SpaceWire transmit bridge: edge-detected N-char FIFO plus a single pending time-code.
// Optional EOP/EEP transfer counter enabled by defining SPW_TX_BRIDGE_EOP_CNT_EN.
module spw_pio_tx_bridge #(
   parameter int DEPTH_LOG2 = 3,
   parameter int DW         = 9
) (
   input  logic          clk_clk,
   input  logic          reset_reset_n,
   input  logic          link_run,
   input  logic [DW-1:0] pio_data,
   input  logic          pio_data_en,
   input  logic [7:0]    pio_timec,
   input  logic          pio_timec_en,
   output logic          pio_data_ready,
   output logic          pio_timec_ready,
   output logic          core_tx_write,
   output logic [DW-1:0] core_tx_data,
   input  logic          core_tx_ready,
   output logic          core_tc_write,
   output logic [7:0]    core_tc_data,
   input  logic          core_tc_ready,
`ifdef SPW_TX_BRIDGE_EOP_CNT_EN
   output logic [15:0]   eop_count,
`endif
   output logic          overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          en_q, tcen_q, link_q;
   logic          tc_pend;
   logic [7:0]    tc_reg;
   logic          data_ready_q;
   logic          full, empty;
   logic          wr_ev, do_wr, tc_ev, tx_fire, tc_fire, link_fall;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign wr_ev     = pio_data_en & ~en_q;
   assign do_wr     = wr_ev & ~full;
   assign tc_ev     = pio_timec_en & ~tcen_q;
   assign link_fall = link_q & ~link_run;

   assign core_tx_write   = link_run & ~empty;
   assign core_tx_data    = core_tx_write ? mem[rd_ptr[PW-2:0]] : '0;
   assign tx_fire         = core_tx_write & core_tx_ready;
   assign core_tc_write   = tc_pend & link_run;
   assign core_tc_data    = tc_reg;
   assign tc_fire         = core_tc_write & core_tc_ready;
   assign pio_timec_ready = ~tc_pend;
   assign pio_data_ready  = data_ready_q;

   always_ff @(posedge clk_clk) begin
      if (do_wr) mem[wr_ptr[PW-2:0]] <= pio_data;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         en_q         <= 1'b0;
         tcen_q       <= 1'b0;
         link_q       <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         overflow     <= 1'b0;
         data_ready_q <= 1'b1;
         tc_pend      <= 1'b0;
         tc_reg       <= '0;
      end else begin
         en_q         <= pio_data_en;
         tcen_q       <= pio_timec_en;
         link_q       <= link_run;
         data_ready_q <= ~full;
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (wr_ev && full) overflow <= 1'b1;
         // A flush discards everything queued before this cycle; a write landing now survives.
         if (link_fall)    rd_ptr <= wr_ptr;
         else if (tx_fire) rd_ptr <= rd_ptr + PW'(1);
         if (link_fall || tc_fire) begin
            tc_pend <= 1'b0;
         end else if (tc_ev && !tc_pend) begin
            tc_pend <= 1'b1;
            tc_reg  <= pio_timec;
         end
      end
   end

`ifdef SPW_TX_BRIDGE_EOP_CNT_EN
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)                   eop_count <= '0;
      else if (tx_fire && core_tx_data[DW-1]) eop_count <= eop_count + 16'd1;
   end
`endif

endmodule

// File: doc/spw_pio_tx_bridge.md
Name: spw_pio_tx_bridge

Overview:
- Sits between the Nios PIO exports (data_tx_to_w, data_en_to_w, timec_tx_to_w, timec_en_to_tx) and the SpaceWire ulight core transmit interface.
- Converts the level-driven software strobes into single-cycle writes.
- Buffers N-chars in a small FIFO and holds one pending time-code.
- Returns ready status to the PIO inputs (data_tx_ready, timec_tx_ready).

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8), each 9 bits wide.
- DW, 9, N-char width: bit 8 is the control flag (1 = EOP/EEP, 0 = data byte).

Ports:
- clk_clk  in  1  system clock; all logic is on its rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- link_run  in  1  high while the core FSM is in Run state.
- pio_data  in  9  N-char from the PIO (data_tx_to_w).
- pio_data_en  in  1  software write strobe (level; rising edge = write).
- pio_timec  in  8  time-code from the PIO (timec_tx_to_w).
- pio_timec_en  in  1  software time-code strobe (level; rising edge = request).
- pio_data_ready  out  1  to data_tx_ready PIO: FIFO not full.
- pio_timec_ready  out  1  to timec_tx_ready PIO: no time-code pending.
- core_tx_write  out  1  N-char write strobe to the core.
- core_tx_data  out  9  N-char to the core.
- core_tx_ready  in  1  core accepts an N-char this cycle if high.
- core_tc_write  out  1  time-code write strobe to the core.
- core_tc_data  out  8  time-code to the core.
- core_tc_ready  in  1  core accepts a time-code this cycle if high.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset values (async, reset_reset_n = 0):
  - FIFO empty, read/write pointers 0.
  - Edge registers 0.
  - core_tx_write = 0, core_tc_write = 0, core_tx_data = 0, core_tc_data = 0.
  - pio_data_ready = 1, pio_timec_ready = 1, overflow = 0.
- Edge detect: en_q registers pio_data_en. A write event is pio_data_en & ~en_q.
  - Data is sampled in the same cycle as the edge.
  - Holding en high writes once only.
- FIFO:
  - Pointers are DEPTH_LOG2+1 bits; full/empty are decided by the MSB compare.
  - Write event while full: entry dropped, overflow set to 1 on the next cycle, pointers unchanged.
  - Write and read in the same cycle while full: the write is still dropped (full is evaluated before the read).
  - Write and read in the same cycle while non-full: both proceed, count unchanged.
- Data output stage:
  - core_tx_write is high whenever link_run = 1 and the FIFO is non-empty.
  - core_tx_data = FIFO head, presented combinationally from registered storage.
  - Transfer happens when core_tx_write & core_tx_ready. The pointer advances on that edge and the next head appears the following cycle.
  - Minimum latency from PIO edge to core_tx_write high: 1 cycle.
- Time-code:
  - A rising edge of pio_timec_en while pio_timec_ready = 1 latches pio_timec into tc_reg and sets tc_pend.
  - An edge while tc_pend is high is ignored; tc_reg is unchanged.
  - core_tc_write = tc_pend & link_run; core_tc_data = tc_reg.
  - tc_pend clears on core_tc_write & core_tc_ready.
  - The time-code path is independent of the FIFO; both may transfer in the same cycle.
- Status outputs:
  - pio_data_ready = ~full, registered, so it updates 1 cycle after the pointer change.
  - pio_timec_ready = ~tc_pend.
- Link loss:
  - While link_run = 0 nothing is presented to the core.
  - On a falling edge of link_run, the FIFO is flushed (rd_ptr := wr_ptr) and tc_pend cleared in that cycle.
  - Writes during link_run = 0 are still accepted into the FIFO.
- overflow is cleared only by reset.

Optional Feature:
- Macro SPW_TX_BRIDGE_EOP_CNT_EN.
- When defined:
  - Adds output eop_count [15:0], reset 0.
  - Increments on each transferred N-char with data[8] = 1.
  - Wraps 0xFFFF -> 0x0000.
  - Not cleared by a link flush.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then link_run = 1, core_tx_ready = 1; write 0x041 via a pio_data_en pulse -> core_tx_write high 1 cycle later with core_tx_data = 0x041; FIFO empty next cycle.
- core_tx_ready = 0; write 9 chars 0x001..0x009 -> pio_data_ready = 0 after the 8th; the 9th is dropped and overflow = 1; release ready -> 0x001..0x008 emitted in order, no 0x009.
- Hold pio_data_en high 20 cycles with data 0x0AA -> exactly one entry written.
- pio_timec = 0x3F edge with core_tc_ready = 0, then second edge with 0x15 -> tc_reg stays 0x3F; raise ready -> one core_tc_write with 0x3F, then pio_timec_ready = 1.
- Fill 5 entries and a pending time-code with core readies low, drop link_run -> FIFO empty, tc_pend = 0, no core strobes; raise link_run -> no stale output.
- With SPW_TX_BRIDGE_EOP_CNT_EN: send 0x100, 0x055, 0x101 -> eop_count = 2; preload near 0xFFFF and send 2 EOPs -> wraps to 0x0001.
